jtkicker_objline: RTL

- Sprite draw engine at the far end of the object scanner's draw/busy handshake.
- Accepts one 16-pixel sprite row per request and fetches its two 32-bit pattern words from SDRAM.
- Maps each pixel through a 256x4 colour PROM and writes opaque pixels into a double line buffer.
- During active video, plays the previous line's buffer out at pixel rate, clearing each entry after it is read.

---
 rtl/jtkicker_objline.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/jtkicker_objline.sv
// Sprite row draw engine: fetches two pattern words per row, writes opaque pixels into a double line buffer.
// Build option JTKICKER_OBJ_FIRSTWINS_EN: on overlap the first opaque pixel drawn is kept.
module jtkicker_objline #(
  parameter int         BYPASS_PROM = 0,
  parameter logic [7:0] HOFFSET     = 8'd6
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        pxl_cen,
  input  logic        cen2,
  input  logic        LHBL,
  input  logic        hinit_x,
  input  logic [8:0]  hdump,
  input  logic        draw,
  output logic        busy,
  input  logic [8:0]  code,
  input  logic [7:0]  xpos,
  input  logic [3:0]  pal,
  input  logic        hflip,
  input  logic        vflip,
  input  logic [3:0]  ysub,
  input  logic [3:0]  prog_data,
  input  logic [7:0]  prog_addr,
  input  logic        prog_en,
  output logic [13:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        rom_cs,
  input  logic        rom_ok,
  output logic [3:0]  pxl
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAW  = 2'd2;

  logic [1:0]  state;
  logic [1:0]  fph;
  logic        half;
  logic        sel;
  logic [3:0]  cnt;
  logic [8:0]  code_l;
  logic [7:0]  xpos_l;
  logic [3:0]  pal_l;
  logic [3:0]  ysub_l;
  logic        hflip_l;
  logic        vflip_l;
  logic [31:0] pat;
  logic [3:0]  pix;
  logic [3:0]  colour;
  logic [7:0]  waddr;
  logic        wen;
  logic [3:0]  lbuf [0:511];
  logic        clr_en;
  logic        clr_bank;
  logic [7:0]  clr_addr;
  logic        unused_hdump;

  assign unused_hdump = hdump[8];
  assign pix   = hflip_l ? pat[3:0] : pat[31:28];
  assign waddr = xpos_l + HOFFSET + {4'd0, cnt};

  generate
    if (BYPASS_PROM != 0) begin : g_bypass
      logic unused_prog;
      assign unused_prog = ^{prog_data, prog_addr, prog_en, pal_l};
      assign colour = pix;
    end else begin : g_prom
      logic [3:0] prom [0:255];
      always_ff @(posedge clk) begin
        if (prog_en) prom[prog_addr] <= prog_data;
      end
      assign colour = prom[{pal_l, pix}];
    end
  endgenerate

  // Colour 0 is transparent; a line start cancels the pixel of that cycle.
`ifdef JTKICKER_OBJ_FIRSTWINS_EN
  assign wen = cen2 && !hinit_x && state == DRAW && colour != 4'd0 && lbuf[{sel, waddr}] == 4'd0;
`else
  assign wen = cen2 && !hinit_x && state == DRAW && colour != 4'd0;
`endif

  // Draw and readout always address opposite banks; the clear of a read entry
  // lands one clk after its read.
  always_ff @(posedge clk) begin
    if (clr_en) lbuf[{clr_bank, clr_addr}] <= 4'd0;
    if (wen) lbuf[{sel, waddr}] <= colour;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pxl      <= 4'd0;
      clr_en   <= 1'b0;
      clr_bank <= 1'b0;
      clr_addr <= 8'd0;
    end else begin
      clr_en <= 1'b0;
      if (pxl_cen) begin
        if (LHBL) begin
          pxl      <= lbuf[{~sel, hdump[7:0]}];
          clr_en   <= 1'b1;
          clr_bank <= ~sel;
          clr_addr <= hdump[7:0];
        end else begin
          pxl <= 4'd0;
        end
      end
    end
  end

  // Handshake: draw is a one-cen2 request honoured only while busy=0; busy rises
  // on the accepting cen2 and falls once the 16th pixel is written or on abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fph      <= 2'd0;
      busy     <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= 14'd0;
      sel      <= 1'b0;
      half     <= 1'b0;
      cnt      <= 4'd0;
      pat      <= 32'd0;
      code_l   <= 9'd0;
      xpos_l   <= 8'd0;
      pal_l    <= 4'd0;
      ysub_l   <= 4'd0;
      hflip_l  <= 1'b0;
      vflip_l  <= 1'b0;
    end else if (cen2) begin
      if (hinit_x) begin
        sel    <= ~sel;
        state  <= IDLE;
        busy   <= 1'b0;
        rom_cs <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (draw) begin
              code_l  <= code;
              xpos_l  <= xpos;
              pal_l   <= pal;
              ysub_l  <= ysub;
              hflip_l <= hflip;
              vflip_l <= vflip;
              busy    <= 1'b1;
              half    <= 1'b0;
              cnt     <= 4'd0;
              fph     <= 2'd0;
              state   <= FETCH;
            end
          end
          FETCH: begin
            // Phase 0 presents the address, phase 1 lets a stale rom_ok pass.
            case (fph)
              2'd0: begin
                rom_addr <= {code_l, ysub_l ^ {4{vflip_l}}, half ^ hflip_l};
                rom_cs   <= 1'b1;
                fph      <= 2'd1;
              end
              2'd1: fph <= 2'd2;
              default: begin
                if (rom_ok) begin
                  pat    <= rom_data;
                  rom_cs <= 1'b0;
                  state  <= DRAW;
                end
              end
            endcase
          end
          DRAW: begin
            pat <= hflip_l ? {4'd0, pat[31:4]} : {pat[27:0], 4'd0};
            cnt <= cnt + 4'd1;
            if (cnt[2:0] == 3'd7) begin
              if (!half) begin
                half  <= 1'b1;
                fph   <= 2'd0;
                state <= FETCH;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
